// File: rtl/weighted_picker_pkg.sv
// Shared types and defaults for the weighted index picker.
package weighted_picker_pkg;

   localparam int N_W_DEF    = 20;
   localparam int W_W_DEF    = 9;
   localparam int NORM_W_DEF = 11;

   // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (state bits 15, 13, 12, 10)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      IDLE,
      DRAW,
      SCAN,
      DONE
   } state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with enable, synchronous load and async reset to SEED.
module lfsr16
   import weighted_picker_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [15:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= SEED;
      end else if (load) begin
         q <= load_val;
      end else if (en) begin
         q <= {q[14:0], ^(q & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/weighted_picker.sv
// Draws index i with probability weight[i]/norm via LFSR rejection sampling and a cumulative scan.
// Optional LFSR reseed port: define WEIGHTED_PICKER_SEED_LOAD_EN.
//
//   state | meaning
//   IDLE  | waiting for start; captures weights and norm
//   DRAW  | one LFSR sample per cycle until r < norm
//   SCAN  | accumulate one weight per cycle until r < acc
//   DONE  | publish index/err, pulse done, drop busy
module weighted_picker
   import weighted_picker_pkg::*;
#(
   parameter int          N_W    = N_W_DEF,
   parameter int          W_W    = W_W_DEF,
   parameter int          NORM_W = NORM_W_DEF,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [N_W*W_W-1:0] weights,
   input  logic [NORM_W-1:0]  norm,
`ifdef WEIGHTED_PICKER_SEED_LOAD_EN
   input  logic               seed_load,
   input  logic [15:0]        seed,
`endif
   output logic               busy,
   output logic               done,
   output logic [4:0]         index,
   output logic               err
);

   state_t                      state;
   logic [N_W-1:0][W_W-1:0]     w_q;
   logic [NORM_W-1:0]           norm_q;
   logic [NORM_W-1:0]           r_q;
   logic [NORM_W:0]             acc_q;
   logic [4:0]                  i_q;
   logic [4:0]                  res_idx;
   logic                        res_err;

   logic [15:0]                 lfsr;
   logic                        lfsr_load;
   logic [15:0]                 lfsr_load_val;
   logic                        start_ok;

   logic [NORM_W-1:0]           mask;
   logic [NORM_W-1:0]           r_cand;
   logic [NORM_W:0]             acc_next;
   logic                        hit;

`ifdef WEIGHTED_PICKER_SEED_LOAD_EN
   assign lfsr_load     = seed_load && (state == IDLE);
   assign lfsr_load_val = (seed == 16'h0000) ? SEED : seed;
   assign start_ok      = start && !seed_load;
`else
   assign lfsr_load     = 1'b0;
   assign lfsr_load_val = SEED;
   assign start_ok      = start;
`endif

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (state == DRAW),
      .load     (lfsr_load),
      .load_val (lfsr_load_val),
      .q        (lfsr)
   );

   // mask is norm_q with every bit below its MSB filled in, i.e. 2^k - 1
   always_comb begin
      mask = '0;
      for (int j = 0; j < NORM_W; j++) begin
         mask[j] = |(norm_q >> j);
      end
   end

   assign r_cand   = lfsr[NORM_W-1:0] & mask;
   assign acc_next = acc_q + {{(NORM_W+1-W_W){1'b0}}, w_q[i_q]};
   assign hit      = {1'b0, r_q} < acc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         index   <= '0;
         err     <= 1'b0;
         w_q     <= '0;
         norm_q  <= '0;
         r_q     <= '0;
         acc_q   <= '0;
         i_q     <= '0;
         res_idx <= '0;
         res_err <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  w_q    <= weights;
                  norm_q <= norm;
                  busy   <= 1'b1;
                  if (norm == '0) begin
                     res_idx <= '0;
                     res_err <= 1'b1;
                     state   <= DONE;
                  end else begin
                     state <= DRAW;
                  end
               end
            end
            DRAW: begin
               if (r_cand < norm_q) begin
                  r_q   <= r_cand;
                  acc_q <= '0;
                  i_q   <= '0;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (hit) begin
                  res_idx <= i_q;
                  res_err <= 1'b0;
                  state   <= DONE;
               end else if (i_q == 5'(N_W-1)) begin
                  // weights summed short of norm: the upstream norm was inconsistent
                  res_idx <= '0;
                  res_err <= 1'b1;
                  state   <= DONE;
               end else begin
                  i_q   <= i_q + 5'd1;
                  acc_q <= acc_next;
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               index <= res_idx;
               err   <= res_err;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weighted_picker.sv
// Randomised self-checking bench for weighted_picker against a behavioural draw model.
module tb_weighted_picker;

   localparam int          N_W    = 20;
   localparam int          W_W    = 9;
   localparam int          NORM_W = 11;
   localparam logic [15:0] SEED   = 16'hACE1;
   localparam int          N_HIST = 2500;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   start = 1'b0;
   logic [N_W*W_W-1:0]     weights = '0;
   logic [NORM_W-1:0]      norm = '0;
   logic                   busy;
   logic                   done;
   logic [4:0]             index;
   logic                   err;
`ifdef WEIGHTED_PICKER_SEED_LOAD_EN
   logic                   seed_load = 1'b0;
   logic [15:0]            seed = '0;
`endif

   int                     errors = 0;
   int                     checks = 0;
   logic [15:0]            m_lfsr = SEED;

   always #5 clk = ~clk;

   weighted_picker dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .weights   (weights),
      .norm      (norm),
`ifdef WEIGHTED_PICKER_SEED_LOAD_EN
      .seed_load (seed_load),
      .seed      (seed),
`endif
      .busy      (busy),
      .done      (done),
      .index     (index),
      .err       (err)
   );

   // one step of the x^16+x^14+x^13+x^11+1 Fibonacci register
   function automatic logic [15:0] ref_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   task automatic model_draw(input logic [N_W*W_W-1:0] w, input logic [NORM_W-1:0] n,
                             output logic [4:0] eidx, output logic eerr, output int elat);
      int mask, r, acc, d, s;
      bit found;
      if (n == 0) begin
         eidx = 0; eerr = 1'b1; elat = 2;
         return;
      end
      mask = 0;
      while (mask < int'(n)) mask = mask * 2 + 1;
      d = 0;
      do begin
         r = int'(m_lfsr[NORM_W-1:0]) & mask;
         m_lfsr = ref_step(m_lfsr);
         d++;
      end while (r >= int'(n));
      acc = 0; found = 0; eidx = 0; eerr = 1'b1; s = N_W;
      for (int i = 0; i < N_W; i++) begin
         acc += int'(w[W_W*i +: W_W]);
         if (!found && r < acc) begin
            found = 1; eidx = 5'(i); eerr = 1'b0; s = i + 1;
         end
      end
      elat = 1 + d + s + 1;
   endtask

   // start pulses randomly while busy and scrambles inputs after capture; both must be ignored
   task automatic do_draw(input logic [N_W*W_W-1:0] w, input logic [NORM_W-1:0] n,
                          output logic [4:0] idx, output logic e, output int lat, output bit to);
      int cnt;
      @(negedge clk);
      weights = w; norm = n; start = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < N_W; i++) weights[W_W*i +: W_W] = W_W'($urandom);
      norm = NORM_W'($urandom);
      start = 1'($urandom);
      cnt = 0; to = 1'b1;
      while (cnt < 400) begin
         @(posedge clk); #1;
         cnt++;
         if (done) begin
            to = 1'b0;
            break;
         end
         start = 1'($urandom);
      end
      start = 1'b0;
      idx = index; e = err; lat = cnt + 1;
   endtask

   task automatic run_check(input string name, input logic [N_W*W_W-1:0] w, input logic [NORM_W-1:0] n,
                            output logic [4:0] idx);
      logic [4:0] eidx; logic eerr, e; int elat, lat; bit to;
      model_draw(w, n, eidx, eerr, elat);
      do_draw(w, n, idx, e, lat, to);
      checks++;
      if (to || idx !== eidx || e !== eerr || lat != elat) begin
         errors++;
         $display("FAIL %s: got idx=%0d err=%0d lat=%0d timeout=%0d, expected idx=%0d err=%0d lat=%0d",
                  name, idx, e, lat, to, eidx, eerr, elat);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy, done, index, err} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%0d done=%0d index=%0d err=%0d, expected all 0", busy, done, index, err);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_lfsr = SEED;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, index, err} !== 8'h00) begin
         errors++;
         $display("FAIL reset_idle: got busy=%0d done=%0d index=%0d err=%0d, expected all 0", busy, done, index, err);
      end
   endtask

   task automatic test_single_last();
      logic [N_W*W_W-1:0] w; logic [4:0] idx;
      w = '0; w[W_W*19 +: W_W] = 9'd13;
      run_check("single_w19", w, 11'd13, idx);
      checks++;
      if (idx !== 5'd19) begin
         errors++;
         $display("FAIL single_w19_idx: got %0d, expected 19", idx);
      end
   endtask

   task automatic test_distribution();
      logic [N_W*W_W-1:0] w; logic [4:0] idx, eidx; logic e, eerr; int elat, lat; bit to;
      int hist [N_W]; int bad;
      real frac, expf;
      w = '0;
      w[W_W*19 +: W_W] = 9'd13; w[W_W*18 +: W_W] = 9'd11; w[W_W*17 +: W_W] = 9'd12;
      w[W_W*16 +: W_W] = 9'd10; w[W_W*15 +: W_W] = 9'd8;
      for (int i = 0; i < N_W; i++) hist[i] = 0;
      bad = 0;
      for (int k = 0; k < N_HIST; k++) begin
         model_draw(w, 11'd54, eidx, eerr, elat);
         do_draw(w, 11'd54, idx, e, lat, to);
         if (to || idx !== eidx || e !== eerr || lat != elat) bad++;
         if (!to) hist[idx]++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL dist_model: %0d of %0d draws disagreed with the reference, expected 0", bad, N_HIST);
      end
      for (int i = 0; i < N_W; i++) begin
         frac = real'(hist[i]) / real'(N_HIST);
         expf = real'(w[W_W*i +: W_W]) / 54.0;
         checks++;
         if (frac - expf > 0.03 || expf - frac > 0.03) begin
            errors++;
            $display("FAIL dist_hist[%0d]: got fraction %f, expected %f +/- 0.03", i, frac, expf);
         end
      end
   endtask

   task automatic test_norm_zero();
      logic [N_W*W_W-1:0] w; logic [4:0] idx;
      for (int i = 0; i < N_W; i++) w[W_W*i +: W_W] = W_W'($urandom_range(0, 50));
      run_check("norm_zero", w, 11'd0, idx);
      run_check("after_norm_zero", w, 11'd1000, idx);
   endtask

   task automatic test_inconsistent();
      logic [N_W*W_W-1:0] w; logic [4:0] idx;
      w = '0; w[0 +: W_W] = 9'd1;
      for (int k = 0; k < 8; k++) run_check("inconsistent", w, 11'd5, idx);
   endtask

   task automatic test_random();
      logic [N_W*W_W-1:0] w; logic [NORM_W-1:0] n; logic [4:0] idx; int sum;
      for (int k = 0; k < 40; k++) begin
         sum = 0;
         for (int i = 0; i < N_W; i++) begin
            w[W_W*i +: W_W] = ($urandom_range(0, 1) == 1) ? W_W'($urandom_range(1, 100)) : '0;
            sum += int'(w[W_W*i +: W_W]);
         end
         n = ($urandom_range(0, 3) == 0) ? NORM_W'($urandom_range(1, 2047)) : NORM_W'(sum);
         run_check("random", w, n, idx);
      end
   endtask

   task automatic test_back_to_back();
      logic [N_W*W_W-1:0] w; logic [4:0] eidx; logic eerr; int elat, cnt, bad, sum;
      sum = 0;
      for (int i = 0; i < N_W; i++) begin
         w[W_W*i +: W_W] = W_W'($urandom_range(0, 60));
         sum += int'(w[W_W*i +: W_W]);
      end
      @(negedge clk);
      weights = w; norm = NORM_W'(sum); start = 1'b1;
      for (int k = 0; k < 6; k++) begin
         model_draw(w, NORM_W'(sum), eidx, eerr, elat);
         cnt = 0; bad = 0;
         do begin
            @(posedge clk); #1;
            cnt++;
            if (busy !== !done) bad++;
         end while (!done && cnt < 400);
         if (k == 5) start = 1'b0;
         checks++;
         if (index !== eidx || err !== eerr || cnt != elat || bad != 0) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got idx=%0d err=%0d spacing=%0d busy_glitches=%0d, expected idx=%0d err=%0d spacing=%0d busy_glitches=0",
                     k, index, err, cnt, bad, eidx, eerr, elat);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL back_to_back_release: got busy=%0d, expected 0", busy);
      end
   endtask

   task automatic test_reset_mid_scan();
      logic [N_W*W_W-1:0] w; logic [4:0] eidx, idx; logic eerr; int elat, d, ndone;
      w = '0; w[W_W*19 +: W_W] = 9'd13;
      model_draw(w, 11'd13, eidx, eerr, elat);
      d = elat - 22;
      @(negedge clk);
      weights = w; norm = 11'd13; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (d + 5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, index, err} !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_scan: got busy=%0d done=%0d index=%0d err=%0d, expected all 0", busy, done, index, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_lfsr = SEED;
      ndone = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL reset_abort: got %0d cycles with done/busy after reset, expected 0", ndone);
      end
      run_check("after_reset", w, 11'd13, idx);
   endtask

`ifdef WEIGHTED_PICKER_SEED_LOAD_EN
   task automatic load_seed(input logic [15:0] s);
      @(negedge clk);
      seed = s; seed_load = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      seed_load = 1'b0; start = 1'b0;
      m_lfsr = (s == 16'h0000) ? SEED : s;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL seed_priority: got busy=%0d, expected 0", busy);
      end
   endtask

   task automatic test_seed_load();
      logic [N_W*W_W-1:0] w; logic [4:0] a [5]; logic [4:0] b [5]; int sum;
      sum = 0;
      for (int i = 0; i < N_W; i++) begin
         w[W_W*i +: W_W] = W_W'($urandom_range(0, 80));
         sum += int'(w[W_W*i +: W_W]);
      end
      load_seed(16'h0001);
      for (int k = 0; k < 5; k++) run_check("seed1_run_a", w, NORM_W'(sum), a[k]);
      load_seed(16'h0001);
      for (int k = 0; k < 5; k++) run_check("seed1_run_b", w, NORM_W'(sum), b[k]);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (a[k] !== b[k]) begin
            errors++;
            $display("FAIL seed_repeat[%0d]: got %0d on rerun, expected %0d", k, b[k], a[k]);
         end
      end
      load_seed(16'h0000);
      for (int k = 0; k < 5; k++) run_check("seed0_run", w, NORM_W'(sum), a[k]);
      load_seed(SEED);
      for (int k = 0; k < 5; k++) run_check("seeddef_run", w, NORM_W'(sum), b[k]);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (a[k] !== b[k]) begin
            errors++;
            $display("FAIL seed_zero[%0d]: got %0d with seed 0, expected %0d as with SEED", k, a[k], b[k]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_last();
      test_norm_zero();
      test_inconsistent();
      test_random();
      test_back_to_back();
      test_reset_mid_scan();
`ifdef WEIGHTED_PICKER_SEED_LOAD_EN
      test_seed_load();
`endif
      test_distribution();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
